memcheck: RTL and testbench

MEMCHECK -- requirements
Module: memcheck

---
 rtl/memcheck.sv | 137 +++++++++++++
 tb/tb_memcheck.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/memcheck.sv
//------------------------------------------------------------------------------
// Module      : memcheck
// Description : Single-cycle memory access legality checker. Each rising
//               edge with memread and/or memwrite high is a request. The
//               request is classified as legal read/write, misaligned,
//               out-of-bounds and/or read/write conflict. All classification
//               outputs are registered pulses one clock after the request.
//               err_sticky latches any error until reset.
// Revision    : 1.0 - initial release
//
// Parameters  : BASE_ADDR  - lowest legal byte address (inclusive)
//               LIMIT_ADDR - highest legal byte address (inclusive)
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               addr       - byte address of the current access
//               memwrite   - write request
//               memread    - read request
//               rd         - legal read accepted (1-cycle pulse)
//               w          - legal write accepted (1-cycle pulse)
//               misalign   - request with addr[1:0] != 0 (1-cycle pulse)
//               oob        - request outside [BASE_ADDR, LIMIT_ADDR]
//               conflict   - memread and memwrite both high
//               err_sticky - any error seen since reset
//               err_cnt    - saturating error-request count (optional)
// Macro       : MEMCHECK_ERRCNT_EN - adds the err_cnt output and counter
//------------------------------------------------------------------------------
`default_nettype none

module memcheck #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] LIMIT_ADDR = 32'h0000_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        memwrite,
  input  logic        memread,
  output logic        rd,
  output logic        w,
  output logic        misalign,
  output logic        oob,
  output logic        conflict,
  output logic        err_sticky
`ifdef MEMCHECK_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  logic        w_rd_req;
  logic        w_wr_req;
  logic        w_req;
  logic        w_misalign;
  logic        w_below;
  logic        w_above;
  logic        w_oob;
  logic        w_conflict;
  logic        w_err;
  logic [32:0] w_lo_diff;
  logic [32:0] w_hi_diff;

  logic        r_rd;
  logic        r_w;
  logic        r_misalign;
  logic        r_oob;
  logic        r_conflict;
  logic        r_err_sticky;

  // Written as if-statements so an unknown request strobe in simulation
  // resolves to "no request" instead of propagating X into the state.
  always_comb begin
    w_rd_req = 1'b0;
    w_wr_req = 1'b0;
    if (memread)
      w_rd_req = 1'b1;
    if (memwrite)
      w_wr_req = 1'b1;
  end

  // Range check via 33-bit borrow: the MSB of each difference is the
  // unsigned "less than" result. This stays well-formed when BASE_ADDR is
  // zero and never wraps around the top of the address space.
  assign w_lo_diff = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign w_hi_diff = {1'b0, LIMIT_ADDR} - {1'b0, addr};
  assign w_below   = 1'(w_lo_diff >> 32);
  assign w_above   = 1'(w_hi_diff >> 32);

  assign w_req      = w_rd_req | w_wr_req;
  assign w_misalign = w_req & (addr[1:0] != 2'b00);
  assign w_oob      = w_req & (w_below | w_above);
  assign w_conflict = w_rd_req & w_wr_req;
  assign w_err      = w_misalign | w_oob | w_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd         <= 1'b0;
      r_w          <= 1'b0;
      r_misalign   <= 1'b0;
      r_oob        <= 1'b0;
      r_conflict   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      // Any error (including a conflict) suppresses both acceptances.
      r_rd       <= w_rd_req & ~w_err;
      r_w        <= w_wr_req & ~w_err;
      r_misalign <= w_misalign;
      r_oob      <= w_oob;
      r_conflict <= w_conflict;
      if (w_err)
        r_err_sticky <= 1'b1;
    end
  end

`ifdef MEMCHECK_ERRCNT_EN
  logic [15:0] r_err_cnt;

  // Counts error requests, holding at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= 16'h0000;
    else if (w_err && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

  assign rd         = r_rd;
  assign w          = r_w;
  assign misalign   = r_misalign;
  assign oob        = r_oob;
  assign conflict   = r_conflict;
  assign err_sticky = r_err_sticky;

endmodule

`default_nettype wire

// File: tb/tb_memcheck.sv
//------------------------------------------------------------------------------
// Module      : tb_memcheck
// Description : Self-checking bench for memcheck (default parameters).
//               Table of directed request vectors with hand-computed
//               expectations, followed by reset, first-edge and latency
//               sequences. err_cnt is exercised when MEMCHECK_ERRCNT_EN
//               is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_memcheck;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [31:0] addr     = 32'h0;
  logic        memwrite = 1'b0;
  logic        memread  = 1'b0;
  logic        rd;
  logic        w;
  logic        misalign;
  logic        oob;
  logic        conflict;
  logic        err_sticky;
`ifdef MEMCHECK_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // addr, request {memread, memwrite},
  // expected {rd, w, misalign, oob, conflict, err_sticky}
  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  req;
    logic [5:0]  exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  memcheck dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .memwrite   (memwrite),
    .memread    (memread),
    .rd         (rd),
    .w          (w),
    .misalign   (misalign),
    .oob        (oob),
    .conflict   (conflict),
    .err_sticky (err_sticky)
`ifdef MEMCHECK_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] e);
    chk({tag, ".rd"},         {31'h0, rd},         {31'h0, e[5]});
    chk({tag, ".w"},          {31'h0, w},          {31'h0, e[4]});
    chk({tag, ".misalign"},   {31'h0, misalign},   {31'h0, e[3]});
    chk({tag, ".oob"},        {31'h0, oob},        {31'h0, e[2]});
    chk({tag, ".conflict"},   {31'h0, conflict},   {31'h0, e[1]});
    chk({tag, ".err_sticky"}, {31'h0, err_sticky}, {31'h0, e[0]});
  endtask

  // Inputs change on the falling edge, so each set is seen by one rising edge.
  task automatic drive(input logic [31:0] a, input logic r, input logic wr);
    @(negedge clk);
    addr     = a;
    memread  = r;
    memwrite = wr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'h0000_0000, 2'b00, 6'b000000}; // idle
    vecs[1]  = '{32'h0000_0008, 2'b01, 6'b010000}; // legal write
    vecs[2]  = '{32'h0000_FFFC, 2'b10, 6'b100000}; // read at top word
    vecs[3]  = '{32'h0000_0000, 2'b10, 6'b100000}; // read at base
    vecs[4]  = '{32'h0000_0001, 2'b00, 6'b000000}; // idle, bad addr ignored
    vecs[5]  = '{32'h0000_0001, 2'b01, 6'b001001}; // misaligned write
    vecs[6]  = '{32'h0000_0002, 2'b10, 6'b001001}; // misaligned read
    vecs[7]  = '{32'h0001_0000, 2'b10, 6'b000101}; // just past limit
    vecs[8]  = '{32'h0000_0004, 2'b11, 6'b000011}; // conflict
    vecs[9]  = '{32'h0000_0004, 2'b00, 6'b000001}; // idle, sticky holds
    vecs[10] = '{32'hFFFF_FFFC, 2'b10, 6'b000101}; // no wrap-around
    vecs[11] = '{32'h0001_0001, 2'b11, 6'b001111}; // all three errors
    vecs[12] = '{32'h0000_FFFF, 2'b01, 6'b001001}; // in range, misaligned
    vecs[13] = '{32'h0000_FFF8, 2'b01, 6'b010001}; // legal write
    vecs[14] = '{32'h0000_0004, 2'b10, 6'b100001}; // legal read
    vecs[15] = '{32'h0000_0000, 2'b00, 6'b000001}; // idle after pulse

    #12;
    chk_all("reset", 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].a, vecs[i].req[1], vecs[i].req[0]);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset between edges while error pulses are high.
    drive(32'h0000_0004, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_all("pre_rst", 6'b000011);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 6'b000000);

    // A legal read present during reset is discarded.
    addr     = 32'h0000_0008;
    memread  = 1'b1;
    memwrite = 1'b0;
    @(posedge clk);
    #1;
    chk_all("in_rst", 6'b000000);
    @(negedge clk);
    memread = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    chk_all("discard", 6'b000000);

    // Request held across release is evaluated on the first edge after it.
    @(negedge clk);
    rst_n    = 1'b0;
    addr     = 32'h0000_000C;
    memwrite = 1'b1;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("first_edge", 6'b010000);

    // New inputs must not reach outputs before the next edge.
    @(negedge clk);
    memwrite = 1'b0;
    memread  = 1'b1;
    addr     = 32'h0000_0010;
    #1;
    chk_all("no_comb", 6'b010000);
    @(posedge clk);
    #1;
    chk_all("latency", 6'b100000);

`ifdef MEMCHECK_ERRCNT_EN
    @(negedge clk);
    rst_n   = 1'b0;
    memread = 1'b0;
    #1;
    chk("cnt_rst", {16'h0, err_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0000_0001, 1'b0, 1'b1);
    drive(32'h0001_0000, 1'b1, 1'b0);
    drive(32'h0000_0004, 1'b1, 1'b1);
    drive(32'h0000_0008, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("cnt_three", {16'h0, err_cnt}, 32'h3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("cnt_cleared", {16'h0, err_cnt}, 32'h0);
    chk_all("cnt_async_rst", 6'b000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
